// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module : alu_cmd_driver
// Brief  : FIFO-buffered command issuer for an 8-bit combinational ALU that
//          returns result, carry, tag and divide-by-zero over valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_a,
    input  logic [7:0]             cmd_b,
    input  logic [3:0]             cmd_mode,
    input  logic [TAG_W-1:0]       cmd_tag,
    output logic [7:0]             alu_a,
    output logic [7:0]             alu_b,
    output logic [3:0]             alu_mode,
    input  logic [7:0]             alu_result,
    input  logic                   alu_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_data,
    output logic                   rsp_cout,
    output logic [TAG_W-1:0]       rsp_tag,
    output logic                   rsp_dz,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int                 c_PTR_W    = $clog2(DEPTH);
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [3:0]         c_MODE_ADD = 4'd0;
    localparam logic [3:0]         c_MODE_DIV = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [7:0]         r_fifo_a    [DEPTH];
    logic [7:0]         r_fifo_b    [DEPTH];
    logic [3:0]         r_fifo_mode [DEPTH];
    logic [TAG_W-1:0]   r_fifo_tag  [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [TAG_W-1:0]   r_tag;
    state_t             r_state;

    logic w_push;
    logic w_issue;
    logic w_empty;

    assign cmd_ready = (fifo_count < c_FULL);
    assign w_empty   = (fifo_count == '0);
    assign w_push    = cmd_valid && cmd_ready;
    // In RESP rsp_valid is always high, so rsp_ready alone marks the handshake.
    assign w_issue   = !w_empty &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
    assign busy      = (r_state != S_IDLE) || !w_empty;

    always_ff @(posedge clk) begin : p_fifo_mem
        if (w_push) begin
            r_fifo_a[r_wr_ptr]    <= cmd_a;
            r_fifo_b[r_wr_ptr]    <= cmd_b;
            r_fifo_mode[r_wr_ptr] <= cmd_mode;
            r_fifo_tag[r_wr_ptr]  <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_ctrl
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
            r_state    <= S_IDLE;
            r_tag      <= '0;
            alu_a      <= 8'd0;
            alu_b      <= 8'd0;
            alu_mode   <= 4'd0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 8'd0;
            rsp_cout   <= 1'b0;
            rsp_tag    <= '0;
            rsp_dz     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_issue})
                2'b10:   fifo_count <= fifo_count + c_CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - c_CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            case (r_state)
                S_EXEC: begin
                    if ((alu_mode == c_MODE_DIV) && (alu_b == 8'd0)) begin
                        rsp_data <= 8'hFF;
                        rsp_dz   <= 1'b1;
                    end else begin
                        rsp_data <= alu_result;
                        rsp_dz   <= 1'b0;
                    end
                    // The ALU reports the add carry in every mode; only add keeps it.
                    rsp_cout  <= (alu_mode == c_MODE_ADD) ? alu_cout : 1'b0;
                    rsp_tag   <= r_tag;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Issue overrides the IDLE fallback above for back-to-back operation.
            if (w_issue) begin
                alu_a    <= r_fifo_a[r_rd_ptr];
                alu_b    <= r_fifo_b[r_rd_ptr];
                alu_mode <= r_fifo_mode[r_rd_ptr];
                r_tag    <= r_fifo_tag[r_rd_ptr];
                r_state  <= S_EXEC;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_cmd_driver
// Brief  : Self-checking bench for alu_cmd_driver with an ALU stub and a
//          queue-based response model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_driver;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_a = 8'd0;
    logic [7:0]       cmd_b = 8'd0;
    logic [3:0]       cmd_mode = 4'd0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic [3:0]       alu_mode;
    logic [7:0]       alu_result;
    logic             alu_cout;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [7:0]       rsp_data;
    logic             rsp_cout;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dz;
    logic             busy;
    logic [$clog2(DEPTH):0] fifo_count;

    alu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cout(rsp_cout), .rsp_tag(rsp_tag), .rsp_dz(rsp_dz),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Combinational ALU stub on the far side of the interface.
    logic [8:0] alu_sum9;
    assign alu_sum9 = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_cout = alu_sum9[8];
    always_comb begin
        alu_result = 8'h00;
        case (alu_mode)
            4'd0:    alu_result = alu_sum9[7:0];
            4'd1:    alu_result = alu_a - alu_b;
            4'd2:    alu_result = alu_a * alu_b;
            4'd3:    alu_result = (alu_b == 8'd0) ? 8'h00 : alu_a / alu_b;
            4'd4:    alu_result = {alu_a[6:0], 1'b0};
            4'd5:    alu_result = {1'b0, alu_a[7:1]};
            4'd6:    alu_result = {alu_a[6:0], alu_a[7]};
            4'd7:    alu_result = {alu_a[0], alu_a[7:1]};
            4'd8:    alu_result = alu_a & alu_b;
            4'd9:    alu_result = alu_a | alu_b;
            4'd10:   alu_result = alu_a ^ alu_b;
            4'd11:   alu_result = ~(alu_a & alu_b);
            4'd12:   alu_result = ~(alu_a | alu_b);
            4'd13:   alu_result = ~(alu_a ^ alu_b);
            4'd14:   alu_result = {7'd0, alu_a > alu_b};
            default: alu_result = {7'd0, alu_a == alu_b};
        endcase
    end

    typedef struct packed {
        logic [7:0]       data;
        logic             cout;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } rsp_t;

    rsp_t exp_q[$];
    int   fire_cyc[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic pushed = 1'b0;

    function automatic rsp_t ref_rsp(input int a, input int b, input int m, input int tag);
        int   r = 0;
        rsp_t e;
        case (m)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a * b;
            3:       r = (b == 0) ? 255 : a / b;
            4:       r = a * 2;
            5:       r = a / 2;
            6:       r = a * 2 + a / 128;
            7:       r = a / 2 + (a % 2) * 128;
            8:       r = a & b;
            9:       r = a | b;
            10:      r = a ^ b;
            11:      r = ~(a & b);
            12:      r = ~(a | b);
            13:      r = ~(a ^ b);
            14:      r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        e.data = 8'(r & 255);
        e.cout = (m == 0) && (a + b > 255);
        e.tag  = TAG_W'(tag);
        e.dz   = (m == 3) && (b == 0);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model bookkeeping at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        pushed = 1'b0;
        if (rst_n) begin
            if (rsp_valid) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                    check("rsp_cout", 32'(rsp_cout), 32'(exp_q[0].cout));
                    check("rsp_tag",  32'(rsp_tag),  32'(exp_q[0].tag));
                    check("rsp_dz",   32'(rsp_dz),   32'(exp_q[0].dz));
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        fire_cyc.push_back(cyc);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(ref_rsp(int'(cmd_a), int'(cmd_b), int'(cmd_mode), int'(cmd_tag)));
                pushed = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] m, input logic [TAG_W-1:0] t);
        logic ok = 1'b0;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_mode = m; cmd_tag = t;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (pushed) begin
                ok = 1'b1;
                break;
            end
        end
        check("send_accept", 32'(ok), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        logic [7:0] mm_a [6] = '{8'h81, 8'h81, 8'd5, 8'd3, 8'd9, 8'hFF};
        logic [7:0] mm_b [6] = '{8'h00, 8'h00, 8'd9, 8'd9, 8'd9, 8'h01};
        logic [3:0] mm_m [6] = '{4'd6, 4'd7, 4'd1, 4'd14, 4'd15, 4'd0};

        // Reset with a command offered: nothing may be pushed.
        cmd_valid = 1'b1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_mode = 4'd2; cmd_tag = 4'd3;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_mode", 32'(alu_mode), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        cmd_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(fifo_count), 32'd0);

        // Single add with latency checks.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 8'd200; cmd_b = 8'd100; cmd_mode = 4'd0; cmd_tag = 4'd5;
        tick();
        check("add_pushed", 32'(pushed), 32'd1);
        cmd_valid = 1'b0;
        check("add_n_alu_a", 32'(alu_a), 32'd0);
        check("add_n_count", 32'(fifo_count), 32'd1);
        check("add_n_busy", 32'(busy), 32'd1);
        tick();
        check("add_n1_alu_a", 32'(alu_a), 32'd200);
        check("add_n1_alu_b", 32'(alu_b), 32'd100);
        check("add_n1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("add_n1_count", 32'(fifo_count), 32'd0);
        tick();
        check("add_n2_rsp_valid", 32'(rsp_valid), 32'd1);
        check("add_n2_data", 32'(rsp_data), 32'h2C);
        check("add_n2_cout", 32'(rsp_cout), 32'd1);
        check("add_n2_tag", 32'(rsp_tag), 32'd5);
        check("add_n2_dz", 32'(rsp_dz), 32'd0);
        drain();
        check("hold_alu_a", 32'(alu_a), 32'd200);

        // Divide by zero, then a normal divide.
        send(8'd7, 8'd0, 4'd3, 4'd1);
        send(8'd7, 8'd2, 4'd3, 4'd2);
        drain();

        // Backpressure: DEPTH queued plus one in flight.
        rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            cmd_valid = 1'b1;
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_mode = 4'($urandom);
            cmd_tag = TAG_W'(accepted);
            tick();
            if (pushed) accepted++;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 32'(accepted), 32'd5);
        check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        check("bp_fifo_count", 32'(fifo_count), 32'd4);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp_rsp_tag0", 32'(rsp_tag), 32'd0);
        fire_cyc.delete();
        rsp_ready = 1'b1;
        tick();
        check("bp_ready_again", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        check("bp_fire_count", 32'(fire_cyc.size()), 32'd5);
        for (int i = 1; i < fire_cyc.size(); i++)
            check("bp_fire_gap", 32'(fire_cyc[i] - fire_cyc[i-1]), 32'd2);
        drain();

        // Mode mix.
        for (int i = 0; i < 6; i++)
            send(mm_a[i], mm_b[i], mm_m[i], TAG_W'(i + 1));
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            cmd_mode  = 4'($urandom);
            cmd_tag   = TAG_W'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset in RESP with three commands queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(8'($urandom), 8'($urandom), 4'($urandom), TAG_W'(i));
        tick();
        check("mr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("mr_fifo_count", 32'(fifo_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", 32'(rsp_valid), 32'd0);
        check("mr_async_count", 32'(fifo_count), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mr_post_valid", 32'(rsp_valid), 32'd0);
            check("mr_post_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
